// File: rtl/replay_buffer_pkg.sv
// Shared sizing and types for the link-layer replay buffer.
package replay_buffer_pkg;

    localparam int DEPTH = 8;        // number of stored entries
    localparam int AW    = 3;        // entry address width
    localparam int DW    = 1024;     // data word width
    localparam int PW    = AW + 1;   // pointer width, top bit is the wrap bit

    typedef logic [PW-1:0] ptr_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] word_t;

    // Per-cycle actions after priority resolution.
    typedef struct packed {
        logic wr;       // store din and advance the write pointer
        logic rd;       // transmit one entry and advance the read pointer
        logic rewind;   // move the read pointer back to the oldest unacked entry
        logic retire;   // move the ack pointer up to the read pointer
    } op_t;

    // Entry address carried by a wrap-bit pointer.
    function automatic addr_t ptr_addr(input ptr_t p);
        return p[AW-1:0];
    endfunction

endpackage

// File: rtl/replay_mem.sv
// Register array with synchronous write and registered synchronous read.
module replay_mem
    import replay_buffer_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_en,
    input  addr_t wr_addr,
    input  word_t wr_data,
    input  logic  rd_en,
    input  addr_t rd_addr,
    output word_t rd_data
);

    word_t mem [DEPTH];

    // Storage array: written on the clock only.
    // NOTE: the array has no reset; only pointers decide what is valid, and resetting 8 kbit of flops buys nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register: loads only on an accepted read, otherwise holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/replay_buffer.sv
// Eight-entry replay buffer: in-order transmit, ack frees sent entries,
// nak rewinds transmit to the oldest unacknowledged entry.
module replay_buffer
    import replay_buffer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          oe,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] r_addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    input  logic          ack,
    input  logic          nak
);

    ptr_t wp;   // next slot to write
    ptr_t rp;   // next slot to transmit
    ptr_t ap;   // oldest unacknowledged slot
    op_t  op;

    // Status from registered pointers; wp - ap wraps modulo 16 so a full ring reads as 8.
    assign full   = (ptr_t'(wp - ap) == ptr_t'(DEPTH));
    assign empty  = (wp == rp);
    assign w_addr = ptr_addr(wp);
    assign r_addr = ptr_addr(rp);

    // Priority resolution: nak blocks oe and ack; writes are independent of both.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch behind.
        op        = '0;
        op.wr     = we && !full;
        op.rewind = nak;
        op.rd     = oe && !empty && !nak;
        op.retire = ack && !nak;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
            ap <= '0;
        end else begin
            if (op.wr) begin
                wp <= wp + ptr_t'(1);
            end
            if (op.rewind) begin
                rp <= ap;
            end else if (op.rd) begin
                rp <= rp + ptr_t'(1);
            end
            if (op.retire) begin
                ap <= rp;
            end
        end
    end

    replay_mem u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (op.wr),
        .wr_addr (ptr_addr(wp)),
        .wr_data (din),
        .rd_en   (op.rd),
        .rd_addr (ptr_addr(rp)),
        .rd_data (dout)
    );

endmodule

// File: tb/tb_replay_buffer.sv
// Directed self-checking bench for replay_buffer.
module tb_replay_buffer;
    import replay_buffer_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          we, oe, ack, nak;
    logic          full, empty;
    logic [AW-1:0] w_addr, r_addr;
    logic [DW-1:0] din, dout;

    int checks = 0;
    int errors = 0;

    replay_buffer dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .oe     (oe),
        .full   (full),
        .empty  (empty),
        .w_addr (w_addr),
        .r_addr (r_addr),
        .din    (din),
        .dout   (dout),
        .ack    (ack),
        .nak    (nak)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Advance one clock; returns 1 time unit after the edge so outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; oe = 1'b0; ack = 1'b0; nak = 1'b0;
    endtask

    task automatic write_word(input word_t d);
        we = 1'b1; din = d;
        tick();
        we = 1'b0;
    endtask

    task automatic read_word();
        oe = 1'b1;
        tick();
        oe = 1'b0;
    endtask

    // Distinct pattern touching every byte lane of the wide word.
    function automatic word_t pat(input int i);
        word_t w;
        for (int k = 0; k < DW / 8; k++) begin
            w[k*8 +: 8] = 8'(8'hA0 + i);
        end
        return w;
    endfunction

    initial begin
        reset = 1'b0;
        idle();
        din = '0;

        // Reset state
        #1;
        check("rst_empty",  word_t'(empty),  word_t'(1));
        check("rst_full",   word_t'(full),   word_t'(0));
        check("rst_w_addr", word_t'(w_addr), word_t'(0));
        check("rst_r_addr", word_t'(r_addr), word_t'(0));
        check("rst_dout",   dout,            word_t'(0));
        #1 reset = 1'b1;

        // Basic write then in-order read
        write_word(word_t'(16'h0001));
        write_word(word_t'(16'h1111));
        check("wr2_w_addr", word_t'(w_addr), word_t'(2));
        check("wr2_empty",  word_t'(empty),  word_t'(0));
        read_word();
        check("rd1_dout",   dout,            word_t'(16'h0001));
        check("rd1_r_addr", word_t'(r_addr), word_t'(1));
        read_word();
        check("rd2_dout",   dout,            word_t'(16'h1111));
        check("rd2_r_addr", word_t'(r_addr), word_t'(2));
        check("rd2_empty",  word_t'(empty),  word_t'(1));

        // Read while empty is ignored
        read_word();
        check("rde_dout",   dout,            word_t'(16'h1111));
        check("rde_r_addr", word_t'(r_addr), word_t'(2));

        // ack (ap <- 2), new word, send, nak replays it
        ack = 1'b1; tick(); ack = 1'b0;
        write_word(word_t'(16'h1101));
        check("wr3_w_addr", word_t'(w_addr), word_t'(3));
        read_word();
        check("rd3_dout",   dout,            word_t'(16'h1101));
        check("rd3_r_addr", word_t'(r_addr), word_t'(3));
        nak = 1'b1; tick(); nak = 1'b0;
        check("nak_r_addr", word_t'(r_addr), word_t'(2));
        check("nak_empty",  word_t'(empty),  word_t'(0));
        check("nak_dout",   dout,            word_t'(16'h1101));
        read_word();
        check("rpl_dout",   dout,            word_t'(16'h1101));
        check("rpl_r_addr", word_t'(r_addr), word_t'(3));

        // Fill from reset, drop the 9th write
        reset = 1'b0; #1 reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_not_full", word_t'(full), word_t'(0));
            write_word(pat(i));
        end
        check("full_flag",   word_t'(full),   word_t'(1));
        check("full_w_addr", word_t'(w_addr), word_t'(0));
        write_word(pat(9));
        check("drop_w_addr", word_t'(w_addr), word_t'(0));
        check("drop_full",   word_t'(full),   word_t'(1));
        for (int i = 0; i < DEPTH; i++) begin
            read_word();
            check("drain_dout", dout, pat(i));
        end
        check("drain_empty", word_t'(empty), word_t'(1));
        check("drain_full",  word_t'(full),  word_t'(1));
        ack = 1'b1; tick(); ack = 1'b0;
        check("ack_full",    word_t'(full),  word_t'(0));
        write_word(word_t'(16'h5555));
        check("reuse_w_addr", word_t'(w_addr), word_t'(1));
        read_word();
        check("reuse_dout",  dout,            word_t'(16'h5555));
        check("reuse_raddr", word_t'(r_addr), word_t'(1));

        // Simultaneous events: wp=9 rp=9 ap=8 here
        write_word(pat(20));
        write_word(pat(21));
        read_word();
        check("pre_sim_dout", dout, pat(20));
        nak = 1'b1; oe = 1'b1; ack = 1'b1;
        tick();
        idle();
        check("sim_r_addr", word_t'(r_addr), word_t'(0));
        check("sim_dout",   dout,            pat(20));
        read_word();
        check("sim_rd_dout", dout, word_t'(16'h5555));
        nak = 1'b1; tick(); nak = 1'b0;
        check("sim_ack_ignored", word_t'(r_addr), word_t'(0));

        // we + oe together on a non-empty, non-full buffer
        we = 1'b1; din = pat(22); oe = 1'b1;
        tick();
        idle();
        check("weoe_w_addr", word_t'(w_addr), word_t'(4));
        check("weoe_r_addr", word_t'(r_addr), word_t'(1));
        check("weoe_dout",   dout,            word_t'(16'h5555));

        // Reset mid-operation with 5 pending entries (wp=14, rp=9)
        write_word(pat(23));
        write_word(pat(24));
        check("pend_w_addr", word_t'(w_addr), word_t'(6));
        reset = 1'b0;
        #1;
        check("mid_w_addr", word_t'(w_addr), word_t'(0));
        check("mid_r_addr", word_t'(r_addr), word_t'(0));
        check("mid_empty",  word_t'(empty),  word_t'(1));
        check("mid_full",   word_t'(full),   word_t'(0));
        check("mid_dout",   dout,            word_t'(0));
        #1 reset = 1'b1;

        // Read alongside a write into an empty buffer is ignored
        we = 1'b1; din = word_t'(16'h0077); oe = 1'b1;
        tick();
        idle();
        check("we_empty_w_addr", word_t'(w_addr), word_t'(1));
        check("we_empty_r_addr", word_t'(r_addr), word_t'(0));
        check("we_empty_dout",   dout,            word_t'(0));
        read_word();
        check("we_empty_rd", dout, word_t'(16'h0077));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/replay_buffer.md
# replay_buffer

Eight-entry, 1024-bit-wide link-layer replay buffer. Upstream logic writes outgoing words into it. The transmit side reads them out in order. Entries stay stored until the far end acknowledges them with `ack`. A negative acknowledge (`nak`) rewinds the transmit pointer so every unacknowledged word is sent again.

## Interface
Parameters (fixed, not overridable at this level):
- DEPTH, 8, number of entries
- AW, 3, address width (log2 DEPTH)
- DW, 1024, data width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- we  in  1  write enable; stores din at w_addr
- oe  in  1  output enable; reads the entry at r_addr onto dout
- full  out  1  all 8 entries hold unacknowledged data
- empty  out  1  no written-but-unsent entry exists
- w_addr  out  3  current write pointer
- r_addr  out  3  current read (transmit) pointer
- din  in  1024  write data
- dout  out  1024  registered read data
- ack  in  1  all entries sent so far are acknowledged; frees them
- nak  in  1  replay request; rewinds r_addr to the oldest unacknowledged entry

## Operation
- Three 4-bit pointers: wp (write), rp (read), ap (oldest unacknowledged). Bit 3 is the wrap bit. w_addr = wp[2:0] and r_addr = rp[2:0].
- Invariant: ap ≤ rp ≤ wp, measured modulo 16.
- full = (wp − ap == 8).
- empty = (wp == rp).
- Write: when we=1 and full=0, mem[wp[2:0]] <= din and wp += 1. When full=1 the write is dropped and no state changes.
- Read: when oe=1, empty=0 and nak=0, dout <= mem[rp[2:0]] and rp += 1. When empty=1, dout holds its value and rp does not change.
- ack: ap <= rp. This frees every entry already transmitted.
- nak: rp <= ap. The next oe re-sends the oldest unacknowledged entry. dout is unchanged that cycle.
- Priority rules when events coincide:
  - nak has priority over oe and ack; both are ignored in a nak cycle.
  - we is independent of nak, oe and ack.
  - full and empty are evaluated on pre-edge pointer values. A write and a read in the same cycle are both legal when their own conditions hold.
  - A read in the same cycle as a write to an empty buffer is ignored.
- Wrap-around: pointers wrap naturally modulo 16, so addresses wrap 7→0.
- Memory contents are not reset.

## Timing
- All state updates on the rising edge of clk.
- Asynchronous reset while reset=0: wp=rp=ap=0, dout=0, so full=0, empty=1, w_addr=0 and r_addr=0. Reset asserted mid-operation discards all pending and unacknowledged data immediately.
- Read latency: dout is valid the cycle after the oe edge, i.e. 1 clock.
- full and empty are combinational from the registered pointers. They update in the cycle after the causing edge.
- A freed slot (after ack) is writable on the next edge.

## Structure
- Shared package `replay_buffer_pkg`: DEPTH, AW, DW, pointer width (AW+1).
- One natural sub-module: `replay_mem`, an 8×1024 synchronous-write, synchronous-read register array. The top level holds the three pointers, the status logic and the priority logic.

## Test plan
- Reset and basic read:
  - reset low → empty=1, full=0, w_addr=0, r_addr=0, dout=0.
  - Release reset; write 0x0001 then 0x1111 → w_addr=2, empty=0.
  - Two oe cycles → dout=0x0001, then 0x1111; r_addr=2, empty=1.
- Read when empty: oe while empty=1 → dout stays 0x1111 and r_addr stays 2.
- ack then nak replay:
  - ack → ap=2.
  - Write 0x1101 → w_addr=3.
  - oe → dout=0x1101, r_addr=3.
  - nak → r_addr=2, empty=0.
  - oe → dout=0x1101 again.
- Full and drop:
  - From reset, write 8 words with no ack → full=1, w_addr=0 (wrapped).
  - 9th write is ignored.
  - Read all 8, then ack → full=0.
  - A new write lands at address 0.
- Simultaneous events:
  - nak+oe+ack in the same cycle → only the rewind happens.
  - we+oe on a non-empty, non-full buffer → both pointers advance.
- Reset mid-operation: assert reset with 5 pending entries → all pointers 0 and empty=1 without waiting for a clock.
